// File: rtl/drive_cmd_rx.sv
// drive_cmd_rx: framed UART drive-command parser with clamp and command-loss watchdog.
// Optional frame statistics outputs are enabled by defining DRIVE_CMD_STATS_EN.
module drive_cmd_rx #(
    parameter int SPEED_LIMIT = 1000,
    parameter int CMD_TIMEOUT = 5000000,
    parameter int BYTE_GAP    = 50000
) (
    input  logic        OSCCLK,
    input  logic        SYSRST,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] left_speed,
    output logic [15:0] right_speed,
    output logic        cmd_update,
    output logic        cmd_timeout,
    output logic        frame_err
`ifdef DRIVE_CMD_STATS_EN
    ,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_bad
`endif
);

    localparam int WD_W  = $clog2(CMD_TIMEOUT + 1);
    localparam int GAP_W = $clog2(BYTE_GAP + 1);

    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(CMD_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(BYTE_GAP - 1);

    localparam logic signed [15:0] LIM_P = 16'(SPEED_LIMIT);
    localparam logic signed [15:0] LIM_N = 16'(-SPEED_LIMIT);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] DRIVE_ID  = 8'h01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ID,
        S_LHI,
        S_LLO,
        S_RHI,
        S_RLO,
        S_CS
    } state_e;

    state_e state_q, state_d;

    logic [GAP_W-1:0] gap_q, gap_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [7:0]       cs_q, cs_d;
    logic [7:0]       lhi_q, lhi_d;
    logic [7:0]       llo_q, llo_d;
    logic [7:0]       rhi_q, rhi_d;
    logic [7:0]       rlo_q, rlo_d;
    logic [15:0]      left_q, left_d;
    logic [15:0]      right_q, right_d;
    logic             upd_q, upd_d;
    logic             err_q, err_d;
    logic             tmo_q, tmo_d;

    logic good_load;
    logic gap_exp;

    // Saturate a signed 16-bit request into [-SPEED_LIMIT, +SPEED_LIMIT].
    function automatic logic [15:0] clamp(input logic [15:0] v);
        logic signed [15:0] s;
        s = signed'(v);
        if (s > LIM_P) begin
            return LIM_P;
        end else if (s < LIM_N) begin
            return LIM_N;
        end else begin
            return v;
        end
    endfunction

    // FSM state register.
    always_ff @(posedge OSCCLK or posedge SYSRST) begin
        if (SYSRST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame decode, byte-gap abort and watchdog next-state logic.
    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        wd_d      = wd_q;
        cs_d      = cs_q;
        lhi_d     = lhi_q;
        llo_d     = llo_q;
        rhi_d     = rhi_q;
        rlo_d     = rlo_q;
        left_d    = left_q;
        right_d   = right_q;
        upd_d     = 1'b0;
        err_d     = 1'b0;
        tmo_d     = tmo_q;
        good_load = 1'b0;

        // A byte landing on the expiry cycle wins over the abort.
        gap_exp = (state_q != S_IDLE) && !rx_valid && (gap_q == GAP_MAX);

        if ((state_q == S_IDLE) || rx_valid || gap_exp) begin
            gap_d = '0;
        end else begin
            gap_d = gap_q + 1'b1;
        end

        if (rx_valid) begin
            unique case (state_q)
                S_IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d = S_ID;
                    end
                end
                S_ID: begin
                    if (rx_data == DRIVE_ID) begin
                        cs_d    = rx_data;
                        state_d = S_LHI;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_LHI: begin
                    lhi_d   = rx_data;
                    cs_d    = cs_q ^ rx_data;
                    state_d = S_LLO;
                end
                S_LLO: begin
                    llo_d   = rx_data;
                    cs_d    = cs_q ^ rx_data;
                    state_d = S_RHI;
                end
                S_RHI: begin
                    rhi_d   = rx_data;
                    cs_d    = cs_q ^ rx_data;
                    state_d = S_RLO;
                end
                S_RLO: begin
                    rlo_d   = rx_data;
                    cs_d    = cs_q ^ rx_data;
                    state_d = S_CS;
                end
                S_CS: begin
                    state_d = S_IDLE;
                    if (rx_data == cs_q) begin
                        good_load = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else if (gap_exp) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
        end

        // A good frame takes priority over a simultaneous watchdog expiry.
        if (good_load) begin
            wd_d    = '0;
            tmo_d   = 1'b0;
            upd_d   = 1'b1;
            left_d  = clamp({lhi_q, llo_q});
            right_d = clamp({rhi_q, rlo_q});
        end else if (wd_q == WD_MAX) begin
            tmo_d   = 1'b1;
            left_d  = '0;
            right_d = '0;
        end else begin
            wd_d = wd_q + 1'b1;
        end
    end

    // Datapath, counters and output registers; reset leaves the rover halted.
    always_ff @(posedge OSCCLK or posedge SYSRST) begin
        if (SYSRST) begin
            gap_q   <= '0;
            wd_q    <= '0;
            cs_q    <= '0;
            lhi_q   <= '0;
            llo_q   <= '0;
            rhi_q   <= '0;
            rlo_q   <= '0;
            left_q  <= '0;
            right_q <= '0;
            upd_q   <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b1;
        end else begin
            gap_q   <= gap_d;
            wd_q    <= wd_d;
            cs_q    <= cs_d;
            lhi_q   <= lhi_d;
            llo_q   <= llo_d;
            rhi_q   <= rhi_d;
            rlo_q   <= rlo_d;
            left_q  <= left_d;
            right_q <= right_d;
            upd_q   <= upd_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    assign left_speed  = left_q;
    assign right_speed = right_q;
    assign cmd_update  = upd_q;
    assign frame_err   = err_q;
    assign cmd_timeout = tmo_q;

`ifdef DRIVE_CMD_STATS_EN
    logic [15:0] ok_q, ok_d;
    logic [15:0] bad_q, bad_d;

    // Saturating good/bad frame counters, stepped alongside the pulses.
    always_comb begin
        ok_d  = ok_q;
        bad_d = bad_q;
        if (upd_d && (ok_q != 16'hFFFF)) begin
            ok_d = ok_q + 16'd1;
        end
        if (err_d && (bad_q != 16'hFFFF)) begin
            bad_d = bad_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge OSCCLK or posedge SYSRST) begin
        if (SYSRST) begin
            ok_q  <= '0;
            bad_q <= '0;
        end else begin
            ok_q  <= ok_d;
            bad_q <= bad_d;
        end
    end

    assign frames_ok  = ok_q;
    assign frames_bad = bad_q;
`endif

endmodule

// File: tb/tb_drive_cmd_rx.sv
// tb_drive_cmd_rx: table-driven frames plus hand-written watchdog, gap and reset sequences.
// Command and error events are checked through a queue of expected events.
module tb_drive_cmd_rx;

    localparam int CT = 3000;
    localparam int BG = 50;

    localparam int K_OK  = 1;
    localparam int K_ERR = 2;

    logic        OSCCLK;
    logic        SYSRST;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] left_speed;
    logic [15:0] right_speed;
    logic        cmd_update;
    logic        cmd_timeout;
    logic        frame_err;
`ifdef DRIVE_CMD_STATS_EN
    logic [15:0] frames_ok;
    logic [15:0] frames_bad;
`endif

    drive_cmd_rx #(
        .SPEED_LIMIT(1000),
        .CMD_TIMEOUT(CT),
        .BYTE_GAP(BG)
    ) dut (
        .OSCCLK(OSCCLK),
        .SYSRST(SYSRST),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .left_speed(left_speed),
        .right_speed(right_speed),
        .cmd_update(cmd_update),
        .cmd_timeout(cmd_timeout),
        .frame_err(frame_err)
`ifdef DRIVE_CMD_STATS_EN
        ,
        .frames_ok(frames_ok),
        .frames_bad(frames_bad)
`endif
    );

    initial OSCCLK = 1'b0;
    always #5 OSCCLK = ~OSCCLK;

    typedef struct {
        logic [63:0] bytes;
        int          n;
        int          kind;
        logic [15:0] l;
        logic [15:0] r;
    } vec_t;

    typedef struct {
        int          kind;
        logic [15:0] l;
        logic [15:0] r;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[10];

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ok   = 0;
    int exp_bad  = 0;

    task automatic check(input string nm, input logic [47:0] act,
                         input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [15:0] l,
                        input logic [15:0] r);
        exp_t e;
        e.kind = kind;
        e.l    = l;
        e.r    = r;
        sbq.push_back(e);
        if (kind == K_OK) exp_ok++;
        else exp_bad++;
    endtask

    task automatic tick(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(negedge OSCCLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
    endtask

    task automatic send(input logic [63:0] bytes, input int n);
        for (int i = 0; i < n; i++) tick(1'b1, bytes[63-8*i -: 8]);
        rx_valid = 1'b0;
    endtask

    // Event monitor: every cmd_update / frame_err pulse must match the queue head.
    always @(posedge OSCCLK) begin
        #1;
        if (!SYSRST && (cmd_update || frame_err)) begin
            exp_t e;
            int   k;
            k = cmd_update ? K_OK : K_ERR;
            if (cmd_update && frame_err) begin
                n_checks++;
                n_fail++;
                $display("FAIL event_both: cmd_update and frame_err together");
            end else if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL event_unexpected: kind %0d l=0x%0h r=0x%0h",
                         k, left_speed, right_speed);
            end else begin
                e = sbq.pop_front();
                check("event", {8'(k), 8'h00, left_speed, right_speed},
                      {8'(e.kind), 8'h00, e.l, e.r});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        vecs[0] = '{64'hA5_01_01_F4_FE_0C_06_00, 7, K_OK,  16'h01F4, 16'hFE0C};
        vecs[1] = '{64'hA5_01_7F_FF_80_00_01_00, 7, K_OK,  16'h03E8, 16'hFC18};
        vecs[2] = '{64'hA5_01_01_F4_FE_0C_07_00, 7, K_ERR, 16'h03E8, 16'hFC18};
        vecs[3] = '{64'hA5_02_00_00_00_00_00_00, 2, K_ERR, 16'h03E8, 16'hFC18};
        vecs[4] = '{64'hA5_01_FC_18_03_E8_0E_00, 7, K_OK,  16'hFC18, 16'h03E8};
        vecs[5] = '{64'hA5_01_03_E9_FC_17_00_00, 7, K_OK,  16'h03E8, 16'hFC18};
        vecs[6] = '{64'hA5_01_00_A5_A5_00_01_00, 7, K_OK,  16'h00A5, 16'hFC18};
        vecs[7] = '{64'h33_A5_01_00_00_00_00_01, 8, K_OK,  16'h0000, 16'h0000};
        vecs[8] = '{64'hA5_01_80_00_00_01_80_00, 7, K_OK,  16'hFC18, 16'h0001};
        vecs[9] = '{64'hA5_01_00_00_00_00_00_00, 7, K_ERR, 16'hFC18, 16'h0001};

        SYSRST   = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge OSCCLK);
        check("rst_left", 48'(left_speed), 48'h0);
        check("rst_right", 48'(right_speed), 48'h0);
        check("rst_timeout", 48'(cmd_timeout), 48'h1);
        check("rst_update", 48'(cmd_update), 48'h0);
        check("rst_err", 48'(frame_err), 48'h0);
        SYSRST = 1'b0;
        idle(2);

        for (int i = 0; i < 10; i++) begin
            push(vecs[i].kind, vecs[i].l, vecs[i].r);
            send(vecs[i].bytes, vecs[i].n);
            idle(3);
            if (vecs[i].kind == K_OK) begin
                check("tbl_timeout", 48'(cmd_timeout), 48'h0);
            end
            check("tbl_hold", {left_speed, right_speed}, {vecs[i].l, vecs[i].r});
        end

        // Reset in the middle of a frame; the tail must then be discarded.
        send(64'hA5_01_01_00_00_00_00_00, 3);
        SYSRST = 1'b1;
        #2;
        check("midrst_speeds", {left_speed, right_speed}, 48'h0);
        check("midrst_timeout", 48'(cmd_timeout), 48'h1);
        exp_ok  = 0;
        exp_bad = 0;
        @(negedge OSCCLK);
        SYSRST = 1'b0;
        idle(2);
        send(64'hF4_FE_0C_06_00_00_00_00, 4);
        idle(3);
        check("midrst_tail", {left_speed, right_speed}, 48'h0);

        // Watchdog expiry boundary.
        push(K_OK, 16'h0064, 16'hFF9C);
        send(64'hA5_01_00_64_FF_9C_06_00, 7);
        idle(CT - 1);
        check("wd_before_tmo", 48'(cmd_timeout), 48'h0);
        check("wd_before_left", 48'(left_speed), 48'h0064);
        idle(1);
        check("wd_expired_tmo", 48'(cmd_timeout), 48'h1);
        check("wd_expired_speeds", {left_speed, right_speed}, 48'h0);

        // Good frame landing on the exact expiry cycle.
        push(K_OK, 16'h01F4, 16'hFE0C);
        send(vecs[0].bytes, 7);
        idle(CT - 7);
        push(K_OK, 16'h0064, 16'hFF9C);
        send(64'hA5_01_00_64_FF_9C_06_00, 7);
        check("wd_race_tmo", 48'(cmd_timeout), 48'h0);
        check("wd_race_speeds", {left_speed, right_speed}, 48'h0064_FF9C);
        idle(3);

        // Byte-gap abort, then a clean frame.
        push(K_ERR, 16'h0064, 16'hFF9C);
        send(64'hA5_01_01_00_00_00_00_00, 3);
        idle(BG - 1);
        check("gap_not_yet", 48'(frame_err), 48'h0);
        idle(1);
        check("gap_abort", 48'(frame_err), 48'h1);
        idle(2);
        push(K_OK, 16'h01F4, 16'hFE0C);
        send(vecs[0].bytes, 7);
        idle(3);

        // Byte arriving on the gap-expiry cycle is accepted.
        push(K_OK, 16'h03E8, 16'hFC18);
        send(64'hA5_01_7F_00_00_00_00_00, 3);
        idle(BG - 1);
        send(64'hFF_80_00_01_00_00_00_00, 4);
        idle(3);
        check("gap_edge_speeds", {left_speed, right_speed}, 48'h03E8_FC18);

`ifdef DRIVE_CMD_STATS_EN
        check("stats_ok", 48'(frames_ok), 48'(exp_ok));
        check("stats_bad", 48'(frames_bad), 48'(exp_bad));
`endif
        check("scoreboard_drained", 48'(sbq.size()), 48'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
